// File: rtl/dht11_ctrl.sv
// DHT11 single-wire reader: host start pulse, sensor response check, 40-bit decode,
// checksum verification and last-good humidity/temperature bytes.
`timescale 1ns/1ps
module dht11_ctrl #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned START_MS   = 20,
  parameter int unsigned BIT_THR_US = 50,
  parameter int unsigned TIMEOUT_US = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick_1khz,
  input  logic       i_start,
  inout  wire        dht_io,
  output logic [7:0] o_humid,
  output logic [7:0] o_temp,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_err_cksum,
  output logic       o_err_tmo
);

  localparam int unsigned US_DIV  = (CLK_FREQ / 1_000_000 > 0) ? CLK_FREQ / 1_000_000 : 1;
  localparam int unsigned DIV_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned MS_W    = $clog2(START_MS + 1);
  localparam int unsigned US_W    = 8;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned FRAME_W = 40;

  localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(US_DIV - 1);
  localparam logic [MS_W-1:0]  MS_END   = MS_W'(START_MS);
  localparam logic [US_W-1:0]  US_MAX   = '1;
  localparam logic [US_W-1:0]  BIT_THR  = US_W'(BIT_THR_US);
  localparam logic [US_W-1:0]  TMO_LIM  = US_W'(TIMEOUT_US);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  typedef enum logic [3:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, DATA_LOW, DATA_HIGH, CHECK, TMO
  } state_t;

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic                 us_tick;
  logic [1:0]           sync_q;
  logic                 line_d;
  logic [MS_W-1:0]      ms_cnt;
  logic [US_W-1:0]      us_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [FRAME_W-1:0]   shreg;
  logic                 drive_low;

  logic                 rise_c;
  logic                 fall_c;
  logic                 tmo_c;
  logic [7:0]           sum_c;

  assign dht_io = drive_low ? 1'b0 : 1'bz;

  // Free-running microsecond strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      us_tick <= 1'b0;
    end else if (div_cnt == DIV_END) begin
      div_cnt <= '0;
      us_tick <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      us_tick <= 1'b0;
    end
  end

  // Line synchronizer; idle level of the pulled-up line is 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      line_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], dht_io};
      line_d <= sync_q[1];
    end
  end

  assign rise_c = ~line_d & sync_q[1];
  assign fall_c = line_d & ~sync_q[1];
  // Abort once the saturated counter would step past the limit
  assign tmo_c  = us_tick && (us_cnt >= TMO_LIM);
  assign sum_c  = 8'(shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ms_cnt      <= '0;
      us_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      drive_low   <= 1'b0;
      o_humid     <= '0;
      o_temp      <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_err_cksum <= 1'b0;
      o_err_tmo   <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_err_cksum <= 1'b0;
      o_err_tmo   <= 1'b0;

      if (rise_c || fall_c) begin
        us_cnt <= '0;
      end else if (us_tick && (us_cnt != US_MAX)) begin
        us_cnt <= us_cnt + US_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (i_start) begin
            state     <= START_LOW;
            ms_cnt    <= '0;
            us_cnt    <= '0;
            drive_low <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        START_LOW: begin
          if (ms_cnt == MS_END) begin
            state     <= RELEASE;
            us_cnt    <= '0;
            drive_low <= 1'b0;
          end else if (i_tick_1khz) begin
            ms_cnt <= ms_cnt + MS_W'(1);
          end
        end
        RELEASE: begin
          if (fall_c) begin
            state  <= RESP_LOW;
            us_cnt <= '0;
          end else if (tmo_c) begin
            state  <= TMO;
            us_cnt <= '0;
          end
        end
        RESP_LOW: begin
          if (rise_c) begin
            state  <= RESP_HIGH;
            us_cnt <= '0;
          end else if (tmo_c) begin
            state  <= TMO;
            us_cnt <= '0;
          end
        end
        RESP_HIGH: begin
          if (fall_c) begin
            state   <= DATA_LOW;
            bit_cnt <= '0;
            us_cnt  <= '0;
          end else if (tmo_c) begin
            state  <= TMO;
            us_cnt <= '0;
          end
        end
        DATA_LOW: begin
          if (rise_c) begin
            state  <= DATA_HIGH;
            us_cnt <= '0;
          end else if (tmo_c) begin
            state  <= TMO;
            us_cnt <= '0;
          end
        end
        DATA_HIGH: begin
          // High width measured in us decides the bit value
          if (fall_c) begin
            shreg   <= {shreg[FRAME_W-2:0], (us_cnt > BIT_THR)};
            bit_cnt <= bit_cnt + BIT_W'(1);
            us_cnt  <= '0;
            state   <= (bit_cnt == LAST_BIT) ? CHECK : DATA_LOW;
          end else if (tmo_c) begin
            state  <= TMO;
            us_cnt <= '0;
          end
        end
        CHECK: begin
          if (sum_c == shreg[7:0]) begin
            o_humid <= shreg[39:32];
            o_temp  <= shreg[23:16];
            o_valid <= 1'b1;
          end else begin
            o_err_cksum <= 1'b1;
          end
          state  <= IDLE;
          us_cnt <= '0;
          o_busy <= 1'b0;
        end
        TMO: begin
          o_err_tmo <= 1'b1;
          state     <= IDLE;
          us_cnt    <= '0;
          o_busy    <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          drive_low <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_ctrl.sv
// Bench for dht11_ctrl: behavioural sensor on a pulled-up line, frame table plus
// directed sequences for start pulse, timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_dht11_ctrl;

  localparam int unsigned CLK_FREQ  = 2_000_000;
  localparam int unsigned US_DIV    = 2;
  localparam int unsigned TICK_CLKS = 20;
  localparam int unsigned START_MS  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_tick_1khz;
  logic       i_start;
  logic       sensor_low;
  wire        dht_line;
  logic [7:0] o_humid;
  logic [7:0] o_temp;
  logic       o_valid;
  logic       o_busy;
  logic       o_err_cksum;
  logic       o_err_tmo;

  int n_total = 0;
  int n_pass  = 0;
  int n_valid = 0;
  int n_ck    = 0;
  int n_tmo   = 0;
  int n_multi = 0;

  pullup (dht_line);
  assign dht_line = sensor_low ? 1'b0 : 1'bz;

  dht11_ctrl #(
    .CLK_FREQ  (CLK_FREQ),
    .START_MS  (START_MS),
    .BIT_THR_US(50),
    .TIMEOUT_US(255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_tick_1khz(i_tick_1khz),
    .i_start    (i_start),
    .dht_io     (dht_line),
    .o_humid    (o_humid),
    .o_temp     (o_temp),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_err_cksum(o_err_cksum),
    .o_err_tmo  (o_err_tmo)
  );

  always #5 clk = ~clk;

  // Compressed "millisecond": one tick every TICK_CLKS clocks
  initial begin
    i_tick_1khz = 1'b0;
    forever begin
      repeat (TICK_CLKS - 1) @(negedge clk);
      i_tick_1khz = 1'b1;
      @(negedge clk);
      i_tick_1khz = 1'b0;
    end
  end

  // Pulse monitor: counts high cycles of each status pulse
  always @(negedge clk) begin
    if (reset) begin
      if (o_valid) n_valid <= n_valid + 1;
      if (o_err_cksum) n_ck <= n_ck + 1;
      if (o_err_tmo) n_tmo <= n_tmo + 1;
      if (int'(o_valid) + int'(o_err_cksum) + int'(o_err_tmo) > 1) n_multi <= n_multi + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic us(input int n);
    repeat (n * US_DIV) @(negedge clk);
  endtask

  task automatic wait_line(input logic val, input int max_clks, output bit ok);
    int t;
    t = 0;
    while (dht_line !== val && t < max_clks) begin
      @(negedge clk);
      t++;
    end
    ok = (dht_line === val);
    if (!ok) begin
      n_total++;
      $display("FAIL wait_line: line never reached %0b within %0d clks", val, max_clks);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Sensor model; abort_bit >= 0 asserts reset 10 us into that bit's high phase
  task automatic run_frame(input logic [39:0] data, input int w0, input int w1, input int abort_bit);
    bit ok;
    pulse_start();
    wait_line(1'b0, 50, ok);
    if (!ok) return;
    wait_line(1'b1, (START_MS + 2) * TICK_CLKS, ok);
    if (!ok) return;
    us(20);
    sensor_low = 1'b1; us(80);
    sensor_low = 1'b0; us(80);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1; us(50);
      sensor_low = 1'b0;
      if (i == abort_bit) begin
        us(10);
        reset = 1'b0;
        return;
      end
      us(data[39-i] ? w1 : w0);
    end
    sensor_low = 1'b1; us(50);
    sensor_low = 1'b0;
    us(5);
  endtask

  typedef struct {
    logic [39:0] data;
    int          w0;
    int          w1;
    logic        exp_valid;
    logic [7:0]  exp_h;
    logic [7:0]  exp_t;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int  sv, sc, st, t, low_clks;
    bit  ok;
    logic [7:0] keep_h, keep_t;

    vecs[0] = '{40'h37_00_19_00_50, 26, 70, 1'b1, 8'h37, 8'h19};
    vecs[1] = '{40'h37_00_19_00_51, 26, 70, 1'b0, 8'h37, 8'h19};
    vecs[2] = '{40'h12_34_1A_05_65, 49, 52, 1'b1, 8'h12, 8'h1A};
    vecs[3] = '{40'hFF_FF_00_02_00, 26, 70, 1'b1, 8'hFF, 8'h00};

    reset = 1'b0; i_start = 1'b0; sensor_low = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_humid", o_humid, 0);
    check("rst_temp", o_temp, 0);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_tmo", o_err_tmo, 0);
    check("rst_line", dht_line, 1);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Frame table
    for (int i = 0; i < 4; i++) begin
      sv = n_valid; sc = n_ck; st = n_tmo;
      run_frame(vecs[i].data, vecs[i].w0, vecs[i].w1, -1);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_valid_cnt", i), n_valid - sv, vecs[i].exp_valid ? 1 : 0);
      check($sformatf("v%0d_cksum_cnt", i), n_ck - sc, vecs[i].exp_valid ? 0 : 1);
      check($sformatf("v%0d_tmo_cnt", i), n_tmo - st, 0);
      check($sformatf("v%0d_humid", i), o_humid, vecs[i].exp_h);
      check($sformatf("v%0d_temp", i), o_temp, vecs[i].exp_t);
      check($sformatf("v%0d_busy", i), o_busy, 0);
    end

    // Start pulse length, ignored i_start while busy, then no-response timeout
    keep_h = o_humid; keep_t = o_temp;
    sv = n_valid; st = n_tmo;
    pulse_start();
    wait_line(1'b0, 50, ok);
    low_clks = 0;
    while (dht_line === 1'b0 && low_clks < 30 * TICK_CLKS) begin
      if (low_clks == 100) i_start = 1'b1;
      if (low_clks == 101) begin
        i_start = 1'b0;
        check("busy_during_start", o_busy, 1);
      end
      @(negedge clk);
      low_clks++;
    end
    check_range("start_low_clks", low_clks, (START_MS - 1) * TICK_CLKS, (START_MS + 1) * TICK_CLKS);
    t = 0;
    while (n_tmo == st && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check_range("tmo_latency_clks", t, 250 * US_DIV, 262 * US_DIV);
    check("tmo_cnt", n_tmo - st, 1);
    check("tmo_no_valid", n_valid - sv, 0);
    check("tmo_busy", o_busy, 0);
    check("tmo_line", dht_line, 1);
    check("tmo_keep_humid", o_humid, keep_h);
    repeat (20) @(negedge clk);
    check("no_queued_start", o_busy, 0);

    // Reset while host drives the line low releases it immediately
    pulse_start();
    wait_line(1'b0, 50, ok);
    repeat (30) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_start_line", dht_line, 1);
    check("rst_start_busy", o_busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Reset during DATA_HIGH of bit 20
    run_frame(vecs[0].data, 26, 70, 20);
    #1;
    check("abort_humid", o_humid, 0);
    check("abort_temp", o_temp, 0);
    check("abort_busy", o_busy, 0);
    check("abort_line", dht_line, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    sv = n_valid; sc = n_ck;
    run_frame(vecs[2].data, 26, 70, -1);
    repeat (4) @(negedge clk);
    check("post_valid_cnt", n_valid - sv, 1);
    check("post_cksum_cnt", n_ck - sc, 0);
    check("post_humid", o_humid, 8'h12);
    check("post_temp", o_temp, 8'h1A);
    check("pulse_exclusive", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
